// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART I/O controller.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  localparam logic [31:0] RX_EMPTY_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head; push-when-full succeeds only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_io_controller.sv
// Memory-mapped UART sequencer: TX/RX byte buffering, transmitter pacing FSM and
// sticky overflow flags.
module uart_io_controller
  import uart_ctrl_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        send_req,
  input  logic [7:0]                  wdata,
  input  logic                        rd_en,
  output logic [31:0]                 rdata,
  input  logic                        clr_err,
  output logic                        tx_full,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        tx_overflow,
  output logic                        rx_overflow,
  output logic                        uart_tx_start,
  output logic [7:0]                  uart_tx_data,
  input  logic                        uart_tx_busy,
  input  logic                        uart_rx_valid,
  input  logic [7:0]                  uart_rx_data
);

  tx_state_t                  state_q, state_d;
  logic [7:0]                 tx_data_q, tx_data_d;
  logic                       tx_ovf_q, tx_ovf_d;
  logic                       rx_ovf_q, rx_ovf_d;

  logic [7:0]                 tx_head, rx_head;
  logic                       tx_empty, tx_pop;
  logic [$clog2(TX_DEPTH):0]  tx_count;
  logic                       rx_full, rx_empty;
  logic                       tx_drop, rx_drop;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (send_req),
    .pop   (tx_pop),
    .din   (wdata),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (uart_rx_valid),
    .pop   (rd_en),
    .din   (uart_rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign tx_pop  = (state_q == START) && !tx_empty;
  assign tx_drop = send_req && tx_full && !tx_pop;
  assign rx_drop = uart_rx_valid && rx_full && !rd_en;

  assign rdata         = rx_empty ? RX_EMPTY_WORD : {24'h0, rx_head};
  assign uart_tx_start = (state_q == START);
  assign uart_tx_data  = tx_data_q;
  assign tx_overflow   = tx_ovf_q;
  assign rx_overflow   = rx_ovf_q;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      // Latch the head on the way into START so the byte is valid during the pulse.
      IDLE: if (tx_count != '0) begin
        state_d   = START;
        tx_data_d = tx_head;
      end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (uart_tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!uart_tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // A new overflow on the same edge as clr_err keeps the flag set.
  always_comb begin
    tx_ovf_d = clr_err ? 1'b0 : tx_ovf_q;
    rx_ovf_d = clr_err ? 1'b0 : rx_ovf_q;
    if (tx_drop) tx_ovf_d = 1'b1;
    if (rx_drop) rx_ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovf_q  <= rx_ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_io_controller.sv
// Directed self-checking bench for uart_io_controller with a simple transmitter busy model.
module tb_uart_io_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        send_req;
  logic [7:0]  wdata;
  logic        rd_en;
  logic [31:0] rdata;
  logic        clr_err;
  logic        tx_full;
  logic [2:0]  rx_count;
  logic        tx_overflow;
  logic        rx_overflow;
  logic        uart_tx_start;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_busy;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;

  int          n_chk = 0;
  int          n_fail = 0;
  int          start_cnt = 0;
  int          busy_cnt = 0;
  logic        busy_hold = 1'b0;
  logic [7:0]  txlog [$];

  uart_io_controller #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .send_req      (send_req),
    .wdata         (wdata),
    .rd_en         (rd_en),
    .rdata         (rdata),
    .clr_err       (clr_err),
    .tx_full       (tx_full),
    .rx_count      (rx_count),
    .tx_overflow   (tx_overflow),
    .rx_overflow   (rx_overflow),
    .uart_tx_start (uart_tx_start),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_busy  (uart_tx_busy),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for 10 cycles starting the cycle after a start pulse.
  assign uart_tx_busy = busy_hold || (busy_cnt != 0);

  always @(posedge clk) begin
    if (!reset) begin
      busy_cnt <= 0;
    end else if (uart_tx_start) begin
      busy_cnt  <= 10;
      start_cnt <= start_cnt + 1;
      txlog.push_back(uart_tx_data);
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rx_push(input logic [7:0] b);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    step();
    uart_rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; send_req = 1'b0; wdata = '0; rd_en = 1'b0; clr_err = 1'b0;
    uart_rx_valid = 1'b0; uart_rx_data = '0;
    step(2);
    chk("rst_start", uart_tx_start, 0);
    chk("rst_txdata", uart_tx_data, 0);
    chk("rst_txfull", tx_full, 0);
    chk("rst_rxcount", rx_count, 0);
    chk("rst_txovf", tx_overflow, 0);
    chk("rst_rxovf", rx_overflow, 0);
    chk("rst_rdata", rdata, 32'hFFFF_FFFF);
    reset = 1'b1;
    step();

    // Single TX byte: start pulse 2 edges after the request.
    send_req = 1'b1; wdata = 8'h41;
    step();
    send_req = 1'b0;
    chk("tx1_start_e1", uart_tx_start, 0);
    step();
    chk("tx1_start_e2", uart_tx_start, 1);
    chk("tx1_data", uart_tx_data, 8'h41);
    step();
    chk("tx1_start_e3", uart_tx_start, 0);
    step(15);
    chk("tx1_pulses", start_cnt, 1);
    chk("tx1_log", txlog[0], 8'h41);
    chk("tx1_hold", uart_tx_data, 8'h41);

    // TX overflow with the transmitter held busy.
    txlog.delete();
    busy_hold = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      send_req = 1'b1; wdata = 8'(i);
      step();
      if (i == 5) begin
        chk("txo_full5", tx_full, 1);
        chk("txo_ovf5", tx_overflow, 0);
      end
    end
    send_req = 1'b0;
    chk("txo_full", tx_full, 1);
    chk("txo_ovf", tx_overflow, 1);
    step(3);
    busy_hold = 1'b0;
    for (int t = 0; t < 300 && txlog.size() < 5; t++) step();
    chk("txo_count", txlog.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < txlog.size()) chk("txo_order", txlog[i], 32'(i + 1));
    step(20);
    chk("txo_nodrop6", txlog.size(), 5);
    chk("txo_sticky", tx_overflow, 1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("txo_clr", tx_overflow, 0);

    // RX path.
    rx_push(8'h5A);
    rx_push(8'hC3);
    chk("rx_head1", rdata, 32'h0000_005A);
    chk("rx_cnt2", rx_count, 2);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("rx_head2", rdata, 32'h0000_00C3);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("rx_empty", rdata, 32'hFFFF_FFFF);
    chk("rx_cnt0", rx_count, 0);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("rx_rdempty", rx_count, 0);

    // RX full, overflow, simultaneous push/pop, clear and set-wins.
    rx_push(8'hAA); rx_push(8'hBB); rx_push(8'hCC); rx_push(8'hDD);
    chk("rxf_cnt4", rx_count, 4);
    chk("rxf_noovf", rx_overflow, 0);
    rx_push(8'hEE);
    chk("rxf_ovf", rx_overflow, 1);
    chk("rxf_cnt", rx_count, 4);
    chk("rxf_head", rdata, 32'h0000_00AA);
    rd_en = 1'b1;
    rx_push(8'h11);
    rd_en = 1'b0;
    chk("rxs_cnt", rx_count, 4);
    chk("rxs_head", rdata, 32'h0000_00BB);
    clr_err = 1'b1;
    rx_push(8'h22);
    clr_err = 1'b0;
    chk("rxs_setwins", rx_overflow, 1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("rxs_clr", rx_overflow, 0);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_b [4] = '{8'hBB, 8'hCC, 8'hDD, 8'h11};
      chk("rxs_drain", rdata, {24'h0, exp_b[i]});
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
    chk("rxs_drained", rdata, 32'hFFFF_FFFF);

    // Reset while in WAIT_DONE with two bytes queued.
    busy_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_req = 1'b1; wdata = 8'(8'h70 + i);
      step();
    end
    send_req = 1'b0;
    step(2);
    reset = 1'b0; busy_hold = 1'b0;
    step();
    reset = 1'b1;
    chk("mrst_txfull", tx_full, 0);
    chk("mrst_start", uart_tx_start, 0);
    chk("mrst_txdata", uart_tx_data, 0);
    begin
      int sc;
      sc = start_cnt;
      step(20);
      chk("mrst_nostart", start_cnt, sc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
